mips_bus_lsu: RTL
=================

MIPS_BUS_LSU -- requirements
Module: mips_bus_lsu

Interface
REQ-001 Parameter ADDR_W, default 32: width of request and bus address.
REQ-002 Parameter TIMEOUT, default 255: max consecutive waitrequest-high cycles per bus beat; 0 disables the timeout.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 req_valid  input  1  core presents a request.
REQ-006 req_ready  output  1  LSU accepts a request (IDLE only).
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-009 req_signed  input  1  sign-extend load result when 1, zero-extend when 0.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_error  output  1  qualifies resp_valid; timeout or reserved size.
REQ-015 address  output  ADDR_W  Avalon word-aligned address, bits [1:0] = 0.
REQ-016 read, write  output  1 each  Avalon strobes, never both high.
REQ-017 waitrequest  input  1  Avalon stall.
REQ-018 writedata  output  32 ; byteenable  output  4 ; readdata  input  32.

Function
REQ-019 The FSM SHALL have states IDLE, BEAT1, BEAT2, RESP; req_ready = (state == IDLE).
REQ-020 On a req_valid && req_ready edge, the LSU SHALL latch write, size, signed, addr and wdata, then enter BEAT1, or enter RESP with resp_error=1 if size=11.
REQ-021 Lanes SHALL be little-endian: lane k = bits [8k+7:8k], with off = addr[1:0] and nbytes = 1/2/4.
REQ-022 An access SHALL be split when off + nbytes > 4: BEAT1 uses lanes off..3 at addr & ~3, and BEAT2 uses lanes 0..(off+nbytes-5) at (addr & ~3) + 4, with the address wrapping modulo 2^ADDR_W.
REQ-023 Non-split accesses SHALL skip BEAT2.
REQ-024 BEAT1 writedata SHALL be wdata << 8*off; BEAT2 writedata SHALL be wdata >> 8*(4-off); unused lanes are don't-care.
REQ-025 read or write SHALL be held with stable address, byteenable and writedata for every cycle of a beat while waitrequest=1.
REQ-026 A beat SHALL complete on the first cycle with waitrequest=0, and readdata SHALL be sampled in that cycle.
REQ-027 Load assembly: BEAT1 lanes off..3 map to result bytes 0..(3-off), and BEAT2 lanes map to the following result bytes.
REQ-028 The load result SHALL be truncated to nbytes, then sign- or zero-extended to 32 bits per the latched signed bit.
REQ-029 The timeout counter SHALL clear at each beat start and increment each cycle waitrequest=1.
REQ-030 On reaching TIMEOUT, the LSU SHALL drop read/write the same cycle and enter RESP with resp_error=1 and resp_rdata=0.
REQ-031 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; the outputs hold their values outside RESP and resp_valid=0.
REQ-032 Latency with zero wait states SHALL be 2 cycles (aligned) or 3 cycles (split) from the accept edge to the resp_valid cycle, plus 1 per waitrequest-high cycle.
REQ-033 req_valid in any state other than IDLE SHALL be ignored and not queued.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and drive read=0, write=0, resp_valid=0, resp_error=0, resp_rdata=0, address=0, byteenable=0, writedata=0, and clear the counter.
REQ-035 Reset asserted mid-beat SHALL abort the transfer with no response; the first request after release SHALL be accepted normally.

Verification
REQ-036 Aligned word load at 0x1000, readdata 0xDEADBEEF, no waits -> one read beat at 0x1000, be=1111, resp_rdata=0xDEADBEEF 2 cycles after accept.
REQ-037 Signed byte load at 0x1003 with readdata 0x80000000 -> be=1000, resp_rdata=0xFFFFFF80; the unsigned case -> 0x00000080.
REQ-038 Word store 0x11223344 at 0x2002 -> beat1 at 0x2000, be=1100, wdata[31:16]=0x3344; beat2 at 0x2004, be=0011, wdata[15:0]=0x1122; resp 3 cycles after accept.
REQ-039 Half load at 0x0FFF_FFFF (ADDR_W=28) -> beat2 address wraps to 0x0000000; assembled result correct.
REQ-040 TIMEOUT=4 with waitrequest held high -> read drops after 4 stall cycles, resp_valid=1 with resp_error=1 and resp_rdata=0.
REQ-041 rst_n pulsed low during 3-cycle stalled BEAT1 -> read=0 immediately, no resp_valid; the next aligned load completes correctly.

Source files
------------

// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: MIPS load/store unit bridging byte/half/word core requests onto a 32-bit Avalon-MM master, splitting unaligned accesses
module mips_bus_lsu #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_error,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   input  logic              waitrequest,
   output logic [31:0]       writedata,
   output logic [3:0]        byteenable,
   input  logic [31:0]       readdata
);
   localparam int CW = $clog2(TIMEOUT + 2);
   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;
   state_t state;
   logic l_write, l_signed;
   logic [1:0] l_size;
   logic [ADDR_W-1:0] l_addr, next_base;
   logic [31:0] l_wdata, rbuf, rd_last, result;
   logic [CW-1:0] cnt;
   logic [7:0] be_req, be_lat;
   logic [4:0] sh_lat;
   logic tmo;

   // Byte lanes across two adjacent words: low nibble is the first beat, high nibble the second
   function automatic logic [7:0] lanes(input logic [1:0] sz, input logic [1:0] off);
      lanes = (sz == 2'b00 ? 8'h01 : sz == 2'b01 ? 8'h03 : 8'h0f) << off;
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] r, input logic [1:0] sz, input logic sg);
      ext = sz == 2'b00 ? {{24{sg & r[7]}}, r[7:0]} : sz == 2'b01 ? {{16{sg & r[15]}}, r[15:0]} : r;
   endfunction

   // Lane masks, second-beat address and load assembly from the latched request
   always_comb begin
      be_req    = lanes(req_size, req_addr[1:0]);
      be_lat    = lanes(l_size, l_addr[1:0]);
      sh_lat    = {l_addr[1:0], 3'b000};
      next_base = {l_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
      rd_last   = state == BEAT2 ? rbuf | (readdata << (6'd32 - {1'b0, sh_lat})) : readdata >> sh_lat;
      result    = ext(rd_last, l_size, l_signed);
      tmo       = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
      req_ready = state == IDLE;
   end

   // Transaction FSM with all bus and response outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         read       <= 1'b0;
         write      <= 1'b0;
         resp_valid <= 1'b0;
         resp_error <= 1'b0;
         resp_rdata <= '0;
         address    <= '0;
         byteenable <= '0;
         writedata  <= '0;
         cnt        <= '0;
         rbuf       <= '0;
         l_write    <= 1'b0;
         l_signed   <= 1'b0;
         l_size     <= 2'b00;
         l_addr     <= '0;
         l_wdata    <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               l_write  <= req_write;
               l_size   <= req_size;
               l_signed <= req_signed;
               l_addr   <= req_addr;
               l_wdata  <= req_wdata;
               cnt      <= '0;
               if (req_size == 2'b11) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_error <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  state      <= BEAT1;
                  address    <= {req_addr[ADDR_W-1:2], 2'b00};
                  byteenable <= be_req[3:0];
                  writedata  <= req_wdata << {req_addr[1:0], 3'b000};
                  read       <= !req_write;
                  write      <= req_write;
               end
            end
            BEAT1, BEAT2: if (!waitrequest) begin
               cnt <= '0;
               if (state == BEAT1 && |be_lat[7:4]) begin
                  state      <= BEAT2;
                  rbuf       <= rd_last;
                  address    <= next_base;
                  byteenable <= be_lat[7:4];
                  writedata  <= l_wdata >> (6'd32 - {1'b0, sh_lat});
               end else begin
                  state      <= RESP;
                  read       <= 1'b0;
                  write      <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_error <= 1'b0;
                  resp_rdata <= l_write ? '0 : result;
               end
            end else if (tmo) begin
               state      <= RESP;
               read       <= 1'b0;
               write      <= 1'b0;
               resp_valid <= 1'b1;
               resp_error <= 1'b1;
               resp_rdata <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
